pattern_scheduler: RTL

PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

---
 rtl/pattern_scheduler_pkg.sv | 43 ++++
 rtl/pattern_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pattern_scheduler_pkg.sv
// Shared definitions for the pattern scheduler: FSM encoding, slot count,
// and the bit positions of the sequence nibbles and the control byte.
package pattern_scheduler_pkg;

  localparam int NSLOTS  = 4;
  localparam int SLOT_W  = 2;
  localparam int BUF_W   = 3;
  localparam int DWELL_W = 6;

  localparam int NIB_W          = 4;
  localparam int NIB_VALID_BIT  = 3;
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_LOOP_BIT  = 1;
  localparam int CTRL_DWELL_LSB = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [BUF_W-1:0] bufidx;
  } slot_nib_t;

  // Slots 0/1 live in seq1 and slots 2/3 in seq2, low nibble first.
  function automatic slot_nib_t slot_nibble(input logic [7:0]        s1,
                                            input logic [7:0]        s2,
                                            input logic [SLOT_W-1:0] idx);
    logic [15:0] seq_word;
    seq_word = {s2, s1};
    return slot_nib_t'(seq_word[{idx, 2'b00} +: NIB_W]);
  endfunction

  function automatic logic slot_valid(input logic [7:0]        s1,
                                      input logic [7:0]        s2,
                                      input logic [SLOT_W-1:0] idx);
    logic [15:0] seq_word;
    seq_word = {s2, s1};
    return seq_word[{idx, 2'b00} + 4'(NIB_VALID_BIT)];
  endfunction

endpackage

// File: rtl/pattern_scheduler.sv
// Steps through up to four buffer slots, holding each for a programmable
// number of ticks, and blocks host serial writes to the buffer being played.
module pattern_scheduler #(
  parameter int NSLOTS = pattern_scheduler_pkg::NSLOTS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seq1,
  input  logic [7:0] seq2,
  input  logic [7:0] seqctrl,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  input  logic       ssel_in,
  input  logic [2:0] saddr_in,
  output logic       ssel_out,
  output logic [2:0] bufp,
  output logic [1:0] slot,
  output logic       busy,
  output logic       slot_pulse,
  output logic       done,
  output logic       conflict
);
  import pattern_scheduler_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [7:0]         seq1_q, seq1_d;
  logic [7:0]         seq2_q, seq2_d;
  logic               loop_q, loop_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [BUF_W-1:0]   bufp_q, bufp_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               slot_pulse_q, slot_pulse_d;
  logic               done_q, done_d;

  slot_nib_t          first_nib;
  slot_nib_t          adv_nib;
  logic [SLOT_W-1:0]  next_slot;
  logic [SLOT_W-1:0]  adv_slot;
  logic               next_valid;
  logic               can_adv;

  // LOAD decides from the live inputs, which are the values being shadowed.
  assign first_nib  = slot_nibble(seq1, seq2, SLOT_W'(0));
  assign next_slot  = slot_q + SLOT_W'(1);
  assign next_valid = slot_valid(seq1_q, seq2_q, next_slot);
  assign adv_slot   = ((slot_q != SLOT_W'(NSLOTS - 1)) && next_valid) ? next_slot : SLOT_W'(0);
  assign adv_nib    = slot_nibble(seq1_q, seq2_q, adv_slot);
  assign can_adv    = adv_nib.valid && ((adv_slot != SLOT_W'(0)) || loop_q);

  always_comb begin
    state_d      = state_q;
    seq1_d       = seq1_q;
    seq2_d       = seq2_q;
    loop_d       = loop_q;
    dwell_d      = dwell_q;
    dwell_cnt_d  = dwell_cnt_q;
    bufp_d       = bufp_q;
    slot_d       = slot_q;
    slot_pulse_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && seqctrl[CTRL_EN_BIT]) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        seq1_d  = seq1;
        seq2_d  = seq2;
        loop_d  = seqctrl[CTRL_LOOP_BIT];
        dwell_d = seqctrl[CTRL_DWELL_LSB +: DWELL_W];
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!first_nib.valid) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d      = ST_PLAY;
          slot_d       = SLOT_W'(0);
          bufp_d       = first_nib.bufidx;
          dwell_cnt_d  = seqctrl[CTRL_DWELL_LSB +: DWELL_W];
          slot_pulse_d = 1'b1;
        end
      end

      ST_PLAY: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (dwell_cnt_q != DWELL_W'(0)) begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end else if (can_adv) begin
            slot_d       = adv_slot;
            bufp_d       = adv_nib.bufidx;
            dwell_cnt_d  = dwell_q;
            slot_pulse_d = 1'b1;
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      seq1_q       <= '0;
      seq2_q       <= '0;
      loop_q       <= 1'b0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      bufp_q       <= '0;
      slot_q       <= '0;
      slot_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq1_q       <= seq1_d;
      seq2_q       <= seq2_d;
      loop_q       <= loop_d;
      dwell_q      <= dwell_d;
      dwell_cnt_q  <= dwell_cnt_d;
      bufp_q       <= bufp_d;
      slot_q       <= slot_d;
      slot_pulse_q <= slot_pulse_d;
      done_q       <= done_d;
    end
  end

  assign bufp       = bufp_q;
  assign slot       = slot_q;
  assign busy       = (state_q == ST_PLAY);
  assign slot_pulse = slot_pulse_q;
  assign done       = done_q;

  // Host writes to the buffer currently on air are swallowed here.
  assign conflict = ssel_in && busy && (saddr_in == bufp_q);
  assign ssel_out = ssel_in && !conflict;

endmodule
